// File: rtl/rp_8bit_bd_arb_if.sv
// Requester-side bus of the data RAM arbiter: request fields toward the arbiter,
// same-cycle acknowledge and one-cycle-latency read return back to the requester.
interface rp_8bit_bd_arb_if #(
    parameter int DAW = 13,
    parameter int IDW = 6
) ();
    // Handshake: req is the valid, ack is the same-cycle accept; while req=1 and
    // ack=0 the requester holds wen/adr/wid/wdt stable. ren marks rid/rdt valid
    // exactly one cycle after the ack of a read.
    logic           req;
    logic           wen;
    logic [DAW-1:0] adr;
    logic [IDW-1:0] wid;
    logic [7:0]     wdt;
    logic           ack;
    logic [7:0]     rdt;
    logic [IDW-1:0] rid;
    logic           ren;

    modport master (output req, wen, adr, wid, wdt, input  ack, rdt, rid, ren);
    modport slave  (input  req, wen, adr, wid, wdt, output ack, rdt, rid, ren);
endinterface

// File: rtl/rp_8bit_bd_arb.sv
// Two-requester arbiter in front of the single-port data RAM: one grant per cycle,
// anti-starvation wait counters, and per-requester read return routing.
module rp_8bit_bd_arb #(
    parameter int DAW  = 13,
    parameter int IDW  = 6,
    parameter int MODE = 1,
    parameter int WMX  = 4
) (
    input  logic                clk,
    input  logic                rst,
    rp_8bit_bd_arb_if.slave     m0,
    rp_8bit_bd_arb_if.slave     m1,
    output logic                s_req_o,
    output logic                s_wen_o,
    output logic [DAW-1:0]      s_adr_o,
    output logic [7:0]          s_wdt_o,
    input  logic [7:0]          s_rdt_i,
    output logic [3:0]          dbg_cnt0_o,
    output logic [3:0]          dbg_cnt1_o,
    output logic                dbg_last_o
);

    if (WMX < 1 || WMX > 15) begin : g_wmx_chk
        $error("rp_8bit_bd_arb: WMX=%0d outside 1..15", WMX);
    end

    localparam logic [3:0] WMX_C = 4'(WMX);

    logic [3:0]     cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic           last_q, last_d;
    logic [DAW-1:0] adr_q;
    logic [7:0]     wdt_q;
    logic           ren0_q, ren0_d, ren1_q, ren1_d;
    logic [IDW-1:0] rid0_q, rid0_d, rid1_q, rid1_d;
    logic [7:0]     rdt0_q, rdt0_d, rdt1_q, rdt1_d;
    logic           g0, g1;
    logic           wr0_hz, wr1_hz;

    // A write racing a read of the same address wins, so the read sees new data.
    assign wr0_hz = m0.wen & ~m1.wen & (m0.adr == m1.adr);
    assign wr1_hz = m1.wen & ~m0.wen & (m0.adr == m1.adr);

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (m0.req && m1.req) begin
            if (cnt0_q == WMX_C)      g0 = 1'b1;
            else if (cnt1_q == WMX_C) g1 = 1'b1;
            else if (wr0_hz)          g0 = 1'b1;
            else if (wr1_hz)          g1 = 1'b1;
            else if (MODE == 0)       g0 = 1'b1;
            else if (last_q)          g0 = 1'b1;
            else                      g1 = 1'b1;
        end else begin
            g0 = m0.req;
            g1 = m1.req;
        end
    end

    always_comb begin
        s_req_o = g0 | g1;
        s_wen_o = (g0 & m0.wen) | (g1 & m1.wen);
        s_adr_o = adr_q;
        s_wdt_o = wdt_q;
        if (g0) begin
            s_adr_o = m0.adr;
            s_wdt_o = m0.wdt;
        end else if (g1) begin
            s_adr_o = m1.adr;
            s_wdt_o = m1.wdt;
        end
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (!m0.req || g0)         cnt0_d = 4'd0;
        else if (cnt0_q != WMX_C)  cnt0_d = cnt0_q + 4'd1;
        if (!m1.req || g1)         cnt1_d = 4'd0;
        else if (cnt1_q != WMX_C)  cnt1_d = cnt1_q + 4'd1;

        last_d = last_q;
        if (g0)      last_d = 1'b0;
        else if (g1) last_d = 1'b1;

        ren0_d = g0 & ~m0.wen;
        ren1_d = g1 & ~m1.wen;
        rid0_d = ren0_d ? m0.wid : rid0_q;
        rid1_d = ren1_d ? m1.wid : rid1_q;
        // Capture the RAM output while it is ours so rdt holds afterwards.
        rdt0_d = ren0_q ? s_rdt_i : rdt0_q;
        rdt1_d = ren1_q ? s_rdt_i : rdt1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= 4'd0;
            cnt1_q <= 4'd0;
            last_q <= 1'b1;
            adr_q  <= '0;
            wdt_q  <= 8'd0;
            ren0_q <= 1'b0;
            ren1_q <= 1'b0;
            rid0_q <= '0;
            rid1_q <= '0;
            rdt0_q <= 8'd0;
            rdt1_q <= 8'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            last_q <= last_d;
            adr_q  <= s_adr_o;
            wdt_q  <= s_wdt_o;
            ren0_q <= ren0_d;
            ren1_q <= ren1_d;
            rid0_q <= rid0_d;
            rid1_q <= rid1_d;
            rdt0_q <= rdt0_d;
            rdt1_q <= rdt1_d;
        end
    end

    assign m0.ack = g0;
    assign m1.ack = g1;
    assign m0.ren = ren0_q;
    assign m1.ren = ren1_q;
    assign m0.rid = rid0_q;
    assign m1.rid = rid1_q;
    assign m0.rdt = ren0_q ? s_rdt_i : rdt0_q;
    assign m1.rdt = ren1_q ? s_rdt_i : rdt1_q;

    assign dbg_cnt0_o = cnt0_q;
    assign dbg_cnt1_o = cnt1_q;
    assign dbg_last_o = last_q;

endmodule

// File: tb/tb_rp_8bit_bd_arb.sv
// Bench for rp_8bit_bd_arb: directed vector table, hand sequences for reset and
// starvation, and randomized traffic checked against a rule-level model.
module tb_rp_8bit_bd_arb;
    localparam int DAW = 13;
    localparam int IDW = 6;
    localparam int WMX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rp_8bit_bd_arb_if #(.DAW(DAW), .IDW(IDW)) m0a ();
    rp_8bit_bd_arb_if #(.DAW(DAW), .IDW(IDW)) m1a ();
    rp_8bit_bd_arb_if #(.DAW(DAW), .IDW(IDW)) m0b ();
    rp_8bit_bd_arb_if #(.DAW(DAW), .IDW(IDW)) m1b ();

    logic           sa_req, sa_wen, sb_req, sb_wen;
    logic [DAW-1:0] sa_adr, sb_adr;
    logic [7:0]     sa_wdt, sb_wdt, sa_rdt;
    logic [7:0]     sb_rdt = 8'h00;
    logic [3:0]     a_cnt0, a_cnt1, b_cnt0, b_cnt1;
    logic           a_last, b_last;

    rp_8bit_bd_arb #(.DAW(DAW), .IDW(IDW), .MODE(1), .WMX(WMX)) dut_rr (
        .clk(clk), .rst(rst), .m0(m0a), .m1(m1a),
        .s_req_o(sa_req), .s_wen_o(sa_wen), .s_adr_o(sa_adr), .s_wdt_o(sa_wdt), .s_rdt_i(sa_rdt),
        .dbg_cnt0_o(a_cnt0), .dbg_cnt1_o(a_cnt1), .dbg_last_o(a_last));

    rp_8bit_bd_arb #(.DAW(DAW), .IDW(IDW), .MODE(0), .WMX(WMX)) dut_fp (
        .clk(clk), .rst(rst), .m0(m0b), .m1(m1b),
        .s_req_o(sb_req), .s_wen_o(sb_wen), .s_adr_o(sb_adr), .s_wdt_o(sb_wdt), .s_rdt_i(sb_rdt),
        .dbg_cnt0_o(b_cnt0), .dbg_cnt1_o(b_cnt1), .dbg_last_o(b_last));

    function automatic logic [7:0] init_val(input int a);
        if (a == 256) return 8'h5A;
        return 8'(a * 5 + 1);
    endfunction

    // Synchronous single-port RAM seen by the round-robin instance.
    logic [7:0] ram_a [8192];
    bit         ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 8192; i++) ram_a[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (sa_req) begin
            if (sa_wen) ram_a[sa_adr] <= sa_wdt;
            else        sa_rdt <= ram_a[sa_adr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic r0, w0; logic [12:0] a0; logic [5:0] i0; logic [7:0] d0;
        logic r1, w1; logic [12:0] a1; logic [5:0] i1; logic [7:0] d1;
        logic k0, k1;
        logic e0; logic [5:0] x0; logic [7:0] y0;
        logic e1; logic [5:0] x1; logic [7:0] y1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r0, w0, input logic [12:0] a0, input logic [5:0] i0, input logic [7:0] d0,
        input logic r1, w1, input logic [12:0] a1, input logic [5:0] i1, input logic [7:0] d1,
        input logic k0, k1,
        input logic e0, input logic [5:0] x0, input logic [7:0] y0,
        input logic e1, input logic [5:0] x1, input logic [7:0] y1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.i0 = i0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.i1 = i1; v.d1 = d1;
        v.k0 = k0; v.k1 = k1;
        v.e0 = e0; v.x0 = x0; v.y0 = y0;
        v.e1 = e1; v.x1 = x1; v.y1 = y1;
        return v;
    endfunction

    task automatic drive_a(input logic r0, w0, input logic [12:0] a0, input logic [5:0] i0,
                           input logic [7:0] d0, input logic r1, w1, input logic [12:0] a1,
                           input logic [5:0] i1, input logic [7:0] d1);
        m0a.req = r0; m0a.wen = w0; m0a.adr = a0; m0a.wid = i0; m0a.wdt = d0;
        m1a.req = r1; m1a.wen = w1; m1a.adr = a1; m1a.wid = i1; m1a.wdt = d1;
    endtask

    // Rule-level reference state for the random phase.
    logic [7:0]  mm [8192];
    logic [13:0] exp_q0[$];
    logic [13:0] exp_q1[$];

    initial begin
        logic        p0v, p0w, p1v, p1w;
        logic [12:0] p0a, p1a;
        logic [5:0]  p0i, p1i;
        logic [7:0]  p0d, p1d;
        logic [13:0] e;
        int          w, last, mc0, mc1;

        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m0b.req = 0; m0b.wen = 0; m0b.adr = 0; m0b.wid = 0; m0b.wdt = 0;
        m1b.req = 0; m1b.wen = 0; m1b.adr = 0; m1b.wid = 0; m1b.wdt = 0;

        repeat (2) @(negedge clk);
        chk("rst_ack0", m0a.ack, 0);
        chk("rst_ren0", m0a.ren, 0);
        chk("rst_ren1", m1a.ren, 0);
        chk("rst_rid0", m0a.rid, 0);
        chk("rst_rdt1", m1a.rdt, 0);
        chk("rst_sreq", sa_req, 0);
        chk("rst_last", a_last, 1);
        chk("rst_cnt",  {a_cnt0, a_cnt1}, 0);
        rst = 1'b0;

        // Contention (reads alternate 0,1,0,1), single read, write-vs-read hazard, back-to-back reads.
        tbl.push_back(mk(1,0,0,1,0,        1,0,1,2,0,         1,0, 0,0,0,           0,0,0));
        tbl.push_back(mk(1,0,2,3,0,        1,0,1,2,0,         0,1, 1,1,8'h01,       0,0,0));
        tbl.push_back(mk(1,0,2,3,0,        1,0,3,4,0,         1,0, 0,0,0,           1,2,8'h06));
        tbl.push_back(mk(1,0,4,5,0,        1,0,3,4,0,         0,1, 1,3,8'h0B,       0,0,0));
        tbl.push_back(mk(1,0,4,5,0,        0,0,0,0,0,         1,0, 0,0,0,           1,4,8'h10));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,0,         0,0, 1,5,8'h15,       0,0,0));
        tbl.push_back(mk(1,0,13'h100,6'h15,0, 0,0,0,0,0,      1,0, 0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,0,         0,0, 1,6'h15,8'h5A,   0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        1,0,5,7,0,         0,1, 0,0,0,           0,0,0));
        tbl.push_back(mk(1,0,13'h200,6'h22,0, 1,1,13'h200,0,8'hA5, 0,1, 0,0,0,      1,7,8'h1A));
        tbl.push_back(mk(1,0,13'h200,6'h22,0, 0,0,0,0,0,      1,0, 0,0,0,           0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,0,         0,0, 1,6'h22,8'hA5,   0,0,0));
        tbl.push_back(mk(1,0,0,1,0,        0,0,0,0,0,         1,0, 0,0,0,           0,0,0));
        tbl.push_back(mk(1,0,1,2,0,        0,0,0,0,0,         1,0, 1,1,8'h01,       0,0,0));
        tbl.push_back(mk(1,0,2,3,0,        0,0,0,0,0,         1,0, 1,2,8'h06,       0,0,0));
        tbl.push_back(mk(1,0,3,4,0,        0,0,0,0,0,         1,0, 1,3,8'h0B,       0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,0,         0,0, 1,4,8'h10,       0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0,0,0,         0,0, 0,0,0,           0,0,0));

        for (int n = 0; n < tbl.size(); n++) begin
            drive_a(tbl[n].r0, tbl[n].w0, tbl[n].a0, tbl[n].i0, tbl[n].d0,
                    tbl[n].r1, tbl[n].w1, tbl[n].a1, tbl[n].i1, tbl[n].d1);
            #1;
            chk($sformatf("vec%0d_ack0", n), m0a.ack, tbl[n].k0);
            chk($sformatf("vec%0d_ack1", n), m1a.ack, tbl[n].k1);
            chk($sformatf("vec%0d_ren0", n), m0a.ren, tbl[n].e0);
            chk($sformatf("vec%0d_ren1", n), m1a.ren, tbl[n].e1);
            if (tbl[n].e0) begin
                chk($sformatf("vec%0d_rid0", n), m0a.rid, tbl[n].x0);
                chk($sformatf("vec%0d_rdt0", n), m0a.rdt, tbl[n].y0);
            end
            if (tbl[n].e1) begin
                chk($sformatf("vec%0d_rid1", n), m1a.rid, tbl[n].x1);
                chk($sformatf("vec%0d_rdt1", n), m1a.rdt, tbl[n].y1);
            end
            @(negedge clk);
        end

        // Reset asserted right after a granted read: the return is dropped.
        drive_a(1, 0, 13'h100, 6'h09, 0, 0, 0, 0, 0, 0);
        #1 chk("mid_ack0", m0a.ack, 1);
        @(posedge clk);
        #2 chk("mid_ren_pre", m0a.ren, 1);
        rst = 1'b1;
        #1 chk("mid_ren_drop", m0a.ren, 0);
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1 chk("mid_ren_after", m0a.ren, 0);
        @(negedge clk);
        drive_a(1, 0, 3, 6'h11, 0, 1, 0, 4, 6'h12, 0);
        #1 chk("mid_rr_ack0", m0a.ack, 1);
        chk("mid_rr_ack1", m1a.ack, 0);
        chk("mid_ren_none", m0a.ren, 0);
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("mid_rr_ren0", m0a.ren, 1);
        chk("mid_rr_rid0", m0a.rid, 6'h11);
        @(negedge clk);

        // Fixed priority starvation guard: m1 forced through after WMX denials.
        for (int k = 0; k < 7; k++) begin
            m0b.req = 1; m0b.wen = 0; m0b.adr = 13'(k); m0b.wid = 6'(k);
            m1b.req = 1; m1b.wen = 0; m1b.adr = 13'h20; m1b.wid = 6'h2A;
            #1;
            chk($sformatf("starve%0d_ack0", k), m0b.ack, (k != WMX));
            chk($sformatf("starve%0d_ack1", k), m1b.ack, (k == WMX));
            chk($sformatf("starve%0d_cnt1", k), b_cnt1, (k <= WMX) ? k : k - WMX - 1);
            @(negedge clk);
        end
        m0b.req = 0; m1b.req = 0;

        // Random traffic from a freshly reset arbiter.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8192; i++) mm[i] = ram_a[i];
        last = 1; mc0 = 0; mc1 = 0;
        p0v = 0; p1v = 0; p0w = 0; p1w = 0;
        p0a = 0; p1a = 0; p0i = 0; p1i = 0; p0d = 0; p1d = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!p0v && $urandom_range(0, 9) < 6) begin
                p0v = 1; p0w = ($urandom_range(0, 9) < 3);
                p0a = 13'($urandom_range(0, 7)); p0i = 6'($urandom); p0d = 8'($urandom);
            end
            if (!p1v && $urandom_range(0, 9) < 6) begin
                p1v = 1; p1w = ($urandom_range(0, 9) < 3);
                p1a = 13'($urandom_range(0, 7)); p1i = 6'($urandom); p1d = 8'($urandom);
            end
            drive_a(p0v, p0w, p0a, p0i, p0d, p1v, p1w, p1a, p1i, p1d);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                chk("rnd_ren0", m0a.ren, 1);
                chk("rnd_rid0", m0a.rid, e[13:8]);
                chk("rnd_rdt0", m0a.rdt, e[7:0]);
            end else chk("rnd_ren0", m0a.ren, 0);
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                chk("rnd_ren1", m1a.ren, 1);
                chk("rnd_rid1", m1a.rid, e[13:8]);
                chk("rnd_rdt1", m1a.rdt, e[7:0]);
            end else chk("rnd_ren1", m1a.ren, 0);

            if (p0v && p1v) begin
                if (mc0 >= WMX)                      w = 0;
                else if (mc1 >= WMX)                 w = 1;
                else if (p0w != p1w && p0a == p1a)   w = p0w ? 0 : 1;
                else                                 w = (last == 0) ? 1 : 0;
            end else if (p0v) w = 0;
            else if (p1v)     w = 1;
            else              w = -1;

            chk("rnd_ack0", m0a.ack, (w == 0));
            chk("rnd_ack1", m1a.ack, (w == 1));
            chk("rnd_sreq", sa_req, (w >= 0));
            chk("rnd_cnt0", a_cnt0, mc0);
            chk("rnd_cnt1", a_cnt1, mc1);
            if (w == 0) begin
                chk("rnd_sadr", sa_adr, p0a);
                chk("rnd_swen", sa_wen, p0w);
                if (p0w) mm[p0a] = p0d;
                else     exp_q0.push_back({p0i, mm[p0a]});
            end else if (w == 1) begin
                chk("rnd_sadr", sa_adr, p1a);
                chk("rnd_swen", sa_wen, p1w);
                if (p1w) mm[p1a] = p1d;
                else     exp_q1.push_back({p1i, mm[p1a]});
            end

            mc0 = (!p0v || w == 0) ? 0 : ((mc0 < WMX) ? mc0 + 1 : mc0);
            mc1 = (!p1v || w == 1) ? 0 : ((mc1 < WMX) ? mc1 + 1 : mc1);
            if (w >= 0) last = w;
            if (w == 0) p0v = 0;
            if (w == 1) p1v = 0;
            @(negedge clk);
        end

        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("drain_ren0", m0a.ren, (exp_q0.size() > 0));
        chk("drain_ren1", m1a.ren, (exp_q1.size() > 0));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
